// File: rtl/edge_frame_sched_pkg.sv
// edge_frame_sched shared types and constants.
// State encoding, Sobel coefficient encodings and coefficient lookup.
package edge_frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] F_POS1 = 32'h3F80_0000;
  localparam logic [31:0] F_POS2 = 32'h4000_0000;
  localparam logic [31:0] F_NEG1 = 32'hBF80_0000;
  localparam logic [31:0] F_NEG2 = 32'hC000_0000;

  localparam int unsigned KADDR_W = 4;

  typedef struct packed {
    logic [31:0] gx;
    logic [31:0] gy;
  } coeff_t;

  // Row-major 3x3 kernel; addresses past the window read as zero.
  function automatic coeff_t sobel_lookup(
    input logic [KADDR_W-1:0] addr
  );
    coeff_t c;
    c = '{gx: F_ZERO, gy: F_ZERO};
    case (addr)
      4'd0: c = '{gx: F_NEG1, gy: F_NEG1};
      4'd1: c = '{gx: F_ZERO, gy: F_NEG2};
      4'd2: c = '{gx: F_POS1, gy: F_NEG1};
      4'd3: c = '{gx: F_NEG2, gy: F_ZERO};
      4'd4: c = '{gx: F_ZERO, gy: F_ZERO};
      4'd5: c = '{gx: F_POS2, gy: F_ZERO};
      4'd6: c = '{gx: F_NEG1, gy: F_POS1};
      4'd7: c = '{gx: F_ZERO, gy: F_POS2};
      4'd8: c = '{gx: F_POS1, gy: F_POS1};
      default: c = '{gx: F_ZERO, gy: F_ZERO};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/edge_frame_sched_sobel_coeff_rom.sv
// Sobel Gx/Gy coefficient source, combinational by kernel address.
// Ports: kernel_addr in [3:0]; coeff_x, coeff_y out [31:0] IEEE-754.
module sobel_coeff_rom
  import edge_frame_sched_pkg::*;
(
  input  logic [KADDR_W-1:0] kernel_addr,
  output logic [31:0]        coeff_x,
  output logic [31:0]        coeff_y
);

  coeff_t c;

  always_comb begin
    c       = sobel_lookup(kernel_addr);
    coeff_x = c.gx;
    coeff_y = c.gy;
  end

endmodule

// File: rtl/edge_frame_sched.sv
// Frame scheduler: admits one frame of windows per start, forwards
// features, supplies Sobel coefficients. Macro EDGE_BINARIZE_EN adds
// a threshold input and binarised out_data. Ports: clk, rst (sync,
// active-low), start/abort, window handshake, conv handshakes,
// kernel_addr/coeff_x/coeff_y, feature in/out, busy/frame_done/err.
module edge_frame_sched
  import edge_frame_sched_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               win_valid,
  output logic               win_ready,
  output logic               conv_data_valid,
  output logic               conv_last_pixel,
  input  logic               conv_data_ready,
  input  logic [KADDR_W-1:0] kernel_addr,
  output logic [31:0]        coeff_x,
  output logic [31:0]        coeff_y,
  input  logic               feat_valid,
  input  logic [7:0]         feat_data,
  input  logic               feat_last,
  output logic               conv_result_ready,
`ifdef EDGE_BINARIZE_EN
  input  logic [7:0]         threshold,
`endif
  output logic               out_valid,
  output logic [7:0]         out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  localparam int NWIN  = (WIDTH - 2) * (HEIGHT - 2);
  localparam int CNT_W = $clog2(NWIN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWIN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] received_q, received_d;
  logic             err_q, err_d;
  logic             frame_done_q, frame_done_d;

  logic             feat_path;
  logic             feat_hs;
  logic             feat_final;

  sobel_coeff_rom u_rom (
    .kernel_addr (kernel_addr),
    .coeff_x     (coeff_x),
    .coeff_y     (coeff_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      issued_q     <= '0;
      received_q   <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Feature path is only live while a frame is outstanding; otherwise
  // stray results are sunk so the convolution engine never stalls.
  always_comb begin
    feat_path = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    out_valid = feat_path & feat_valid;
    out_last  = feat_path & feat_last;
    conv_result_ready = feat_path ? out_ready : 1'b1;
    feat_hs    = out_valid & out_ready;
    feat_final = feat_hs && (received_q == LAST_IDX);
  end

`ifdef EDGE_BINARIZE_EN
  assign out_data = (feat_data >= threshold) ? 8'hFF : 8'h00;
`else
  assign out_data = feat_data;
`endif

  always_comb begin
    state_d         = state_q;
    issued_d        = issued_q;
    received_d      = received_q;
    err_d           = err_q;
    frame_done_d    = 1'b0;
    win_ready       = 1'b0;
    conv_data_valid = 1'b0;
    conv_last_pixel = 1'b0;

    if (feat_hs) begin
      received_d = received_q + CNT_ONE;
      // feat_last must mark exactly the final feature of the frame.
      if (feat_final != feat_last) err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        issued_d   = '0;
        received_d = '0;
        if (start) begin
          state_d = ST_RUN;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        conv_data_valid = win_valid;
        win_ready       = win_valid & conv_data_ready;
        conv_last_pixel = (issued_q == LAST_IDX);
        if (win_ready) begin
          issued_d = issued_q + CNT_ONE;
          if (issued_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (feat_final) begin
          state_d      = ST_DONE;
          frame_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d      = ST_IDLE;
      issued_d     = '0;
      received_d   = '0;
      err_d        = err_q;
      frame_done_d = 1'b0;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_edge_frame_sched.sv
// Directed bench for edge_frame_sched at WIDTH=5, HEIGHT=5 (9 windows).
// Bench acts as line buffer, convolution engine and downstream sink.
module tb_edge_frame_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic       win_valid, win_ready;
  logic       conv_data_valid, conv_last_pixel, conv_data_ready;
  logic [3:0] kernel_addr;
  logic [31:0] coeff_x, coeff_y;
  logic       feat_valid, feat_last, conv_result_ready;
  logic [7:0] feat_data;
  logic       out_valid, out_last, out_ready;
  logic [7:0] out_data;
  logic       busy, frame_done, err;
`ifdef EDGE_BINARIZE_EN
  logic [7:0] threshold = 8'd40;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  edge_frame_sched #(.WIDTH(5), .HEIGHT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_valid(win_valid), .win_ready(win_ready),
    .conv_data_valid(conv_data_valid),
    .conv_last_pixel(conv_last_pixel),
    .conv_data_ready(conv_data_ready),
    .kernel_addr(kernel_addr),
    .coeff_x(coeff_x), .coeff_y(coeff_y),
    .feat_valid(feat_valid), .feat_data(feat_data),
    .feat_last(feat_last),
    .conv_result_ready(conv_result_ready),
`ifdef EDGE_BINARIZE_EN
    .threshold(threshold),
`endif
    .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  function automatic logic [7:0] exp_out(input logic [7:0] d);
`ifdef EDGE_BINARIZE_EN
    return (d >= threshold) ? 8'hFF : 8'h00;
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] enc(input int v);
    case (v)
      1:  return 32'h3F800000;
      2:  return 32'h40000000;
      -1: return 32'hBF800000;
      -2: return 32'hC0000000;
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic [7:0] fdat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; win_valid = 0; conv_data_ready = 0;
    feat_valid = 0; feat_data = 0; feat_last = 0; out_ready = 0;
  endtask

  task automatic push_windows(input int n);
    for (int i = 0; i < n; i++) begin
      win_valid = 1; conv_data_ready = 1;
      #1;
      checks++;
      if (win_ready !== 1'b1 || conv_last_pixel !== (i == 8)) begin
        errors++;
        $display("FAIL win%0d: ready=%b last=%b want ready=1 last=%b",
                 i, win_ready, conv_last_pixel, i == 8);
      end
      step();
      win_valid = 0; conv_data_ready = 0;
    end
  endtask

  task automatic run_frame(input string tag, input int bad_idx);
    start = 1; step(); start = 0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b err=%b want 1 0", tag, busy, err);
    end
    push_windows(9);
    win_valid = 1; conv_data_ready = 1; #1;
    checks++;
    if (conv_data_valid !== 1'b0 || win_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: cdv=%b wr=%b busy=%b want 0 0 1",
               tag, conv_data_valid, win_ready, busy);
    end
    win_valid = 0; conv_data_ready = 0;
    for (int i = 0; i < 9; i++) begin
      feat_valid = 1; feat_data = fdat(i);
      feat_last = (i == 8) || (i == bad_idx); out_ready = 1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_out(fdat(i)) ||
          out_last !== feat_last) begin
        errors++;
        $display("FAIL %s feat%0d: v=%b d=%h l=%b want 1 %h %b", tag, i,
                 out_valid, out_data, out_last, exp_out(fdat(i)), feat_last);
      end
      step();
      feat_valid = 0; feat_last = 0; out_ready = 0;
      if (i == bad_idx) begin
        checks++;
        if (err !== 1'b1) begin
          errors++;
          $display("FAIL %s err_set: err=%b want 1", tag, err);
        end
      end
      if (i < 8) begin
        checks++;
        if (frame_done !== 1'b0) begin
          errors++;
          $display("FAIL %s early_done%0d: frame_done=%b want 0",
                   tag, i, frame_done);
        end
      end
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b1 || err !== (bad_idx >= 0)) begin
      errors++;
      $display("FAIL %s done: fd=%b busy=%b err=%b want 1 1 %b",
               tag, frame_done, busy, err, bad_idx >= 0);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: fd=%b busy=%b want 0 0", tag, frame_done, busy);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; step(); step(); rst = 1;
    #1;
    checks++;
    if (busy !== 0 || frame_done !== 0 || err !== 0 || win_ready !== 0 ||
        conv_data_valid !== 0 || conv_last_pixel !== 0 ||
        out_valid !== 0 || conv_result_ready !== 1) begin
      errors++;
      $display("FAIL reset: busy=%b fd=%b err=%b wr=%b cdv=%b clp=%b ov=%b crr=%b",
               busy, frame_done, err, win_ready, conv_data_valid,
               conv_last_pixel, out_valid, conv_result_ready);
    end
  endtask

  task automatic test_coeff();
    int gx[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int gy[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    logic [31:0] ex, ey;
    for (int a = 0; a < 16; a++) begin
      kernel_addr = 4'(a);
      ex = (a < 9) ? enc(gx[a]) : 32'h0;
      ey = (a < 9) ? enc(gy[a]) : 32'h0;
      #1;
      checks++;
      if (coeff_x !== ex || coeff_y !== ey) begin
        errors++;
        $display("FAIL coeff%0d: x=%h y=%h want %h %h",
                 a, coeff_x, coeff_y, ex, ey);
      end
    end
    kernel_addr = 4'd3; #1;
    checks++;
    if (coeff_x !== 32'hC0000000 || coeff_y !== 32'h00000000) begin
      errors++;
      $display("FAIL coeff3_fixed: x=%h y=%h want c0000000 00000000",
               coeff_x, coeff_y);
    end
    kernel_addr = 4'd7; #1;
    checks++;
    if (coeff_y !== 32'h40000000) begin
      errors++;
      $display("FAIL coeff7_fixed: y=%h want 40000000", coeff_y);
    end
  endtask

  task automatic test_frame();
    run_frame("frame", -1);
  endtask

  task automatic test_backpressure();
    int k = 0;
    int got = 0;
    start = 1; step(); start = 0;
    push_windows(9);
    while (got < 9 && k < 100) begin
      feat_valid = 1; feat_data = fdat(got); feat_last = (got == 8);
      out_ready = (k % 3 == 0);
      #1;
      checks++;
      if (conv_result_ready !== out_ready || out_valid !== 1'b1 ||
          out_data !== exp_out(fdat(got))) begin
        errors++;
        $display("FAIL bp cyc%0d: crr=%b ov=%b d=%h want %b 1 %h", k,
                 conv_result_ready, out_valid, out_data, out_ready,
                 exp_out(fdat(got)));
      end
      if (out_ready) got++;
      step();
      k++;
    end
    feat_valid = 0; feat_last = 0; out_ready = 0;
    checks++;
    if (got !== 9 || frame_done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL bp end: got=%0d fd=%b err=%b want 9 1 0",
               got, frame_done, err);
    end
    step();
  endtask

  task automatic test_abort();
    start = 1; step(); start = 0;
    push_windows(4);
    abort = 1; step(); abort = 0;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b fd=%b want 0 0", busy, frame_done);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: fd=%b busy=%b want 0 0", frame_done, busy);
    end
    start = 1; abort = 1; step(); start = 0; abort = 0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: busy=%b want 0", busy);
    end
    run_frame("post_abort", -1);
  endtask

  task automatic test_err();
    run_frame("bad_last", 4);
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b want 1", err);
    end
    run_frame("err_clear", -1);
  endtask

  task automatic test_reset_drain();
    start = 1; step(); start = 0;
    push_windows(9);
    for (int i = 0; i < 3; i++) begin
      feat_valid = 1; feat_data = fdat(i); feat_last = 0; out_ready = 1;
      step();
    end
    feat_valid = 0; out_ready = 0;
    rst = 0; step(); rst = 1;
    checks++;
    if (busy !== 0 || frame_done !== 0 || err !== 0 || win_ready !== 0 ||
        conv_data_valid !== 0 || out_valid !== 0 || conv_result_ready !== 1) begin
      errors++;
      $display("FAIL rst_drain: busy=%b fd=%b err=%b wr=%b cdv=%b ov=%b crr=%b",
               busy, frame_done, err, win_ready, conv_data_valid,
               out_valid, conv_result_ready);
    end
    run_frame("post_rst", -1);
  endtask

  initial begin
    kernel_addr = 0;
    rst = 0;
    idle_inputs();
    test_reset();
    test_coeff();
    test_frame();
    test_backpressure();
    test_abort();
    test_err();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, want completion");
    $fatal(1);
  end

endmodule

// File: doc/edge_frame_sched.md
# edge_frame_sched

Frame-level scheduler and kernel-coefficient source for the floating-point Sobel convolution datapath. Sits between the line-buffer window generator and the convolution engine. Admits exactly one frame's worth of 3x3 windows per start command, tags the final window, supplies Gx/Gy coefficients by kernel address, forwards feature results downstream under backpressure and reports frame completion and protocol errors.

## Interface
- WIDTH, 640, frame width in pixels
- HEIGHT, 480, frame height in pixels
- NWIN (localparam), (WIDTH-2)*(HEIGHT-2), windows per frame (304964 at default)
- CNT_W (localparam), $clog2(NWIN+1), window/feature counter width

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  frame start pulse; honoured only in IDLE
- abort  in  1  abandon current frame; honoured in any state
- win_valid  in  1  window available from line buffer
- win_ready  out  1  window consumed (pops line buffer)
- conv_data_valid  out  1  to convolution in_data_valid
- conv_last_pixel  out  1  to convolution in_last_pixel
- conv_data_ready  in  1  convolution ready (high on 9th coefficient cycle)
- kernel_addr  in  4  convolution kernel address, 0..8
- coeff_x  out  32  IEEE-754 Gx coefficient for kernel_addr
- coeff_y  out  32  IEEE-754 Gy coefficient for kernel_addr
- feat_valid  in  1  feature result valid from convolution
- feat_data  in  8  feature magnitude from convolution
- feat_last  in  1  last-pixel tag from convolution
- conv_result_ready  out  1  to convolution in_result_ready
- out_valid  out  1  feature to downstream
- out_data  out  8  feature (or binarised edge, see Configuration)
- out_last  out  1  last feature of frame
- out_ready  in  1  downstream ready
- busy  out  1  state is not IDLE
- frame_done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol error

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: counters cleared; start -> RUN.
- RUN: conv_data_valid = win_valid; win_ready = win_valid & conv_data_ready; each win_ready increments issued count. conv_last_pixel = 1 while issued == NWIN-1. Acceptance of window NWIN-1 -> DRAIN.
- DRAIN: conv_data_valid = 0, win_ready = 0. Wait for final feature handshake -> DONE.
- DONE: frame_done = 1 for one cycle -> IDLE.
- Feature path (RUN, DRAIN): out_valid = feat_valid, out_data/out_last pass through, conv_result_ready = out_ready. Each out_valid & out_ready increments received count. In IDLE/DONE conv_result_ready = 1 and out_valid = 0 (stray results discarded).
- Final feature: the handshake where received == NWIN-1. err set if feat_last is absent on it, or present on any earlier one; the count rule governs DRAIN exit regardless.
- abort: next state IDLE, counters cleared, err unchanged, no frame_done. abort has priority over every other transition.
- start while not IDLE ignored; start and abort together in IDLE -> stay IDLE.
- Coefficients (combinational): Gx = -1,0,1,-2,0,2,-1,0,1; Gy = -1,-2,-1,0,0,0,1,2,1 for addr 0..8; addr 9..15 -> 0x00000000. Encodings: 1.0=0x3F800000, 2.0=0x40000000, -1.0=0xBF800000, -2.0=0xC0000000.
- err cleared only by reset or by start accepted in IDLE.

## Timing
- Reset (rst=0 at clk edge): state IDLE, counts 0, err 0, frame_done 0; all control outputs 0 except conv_result_ready = 1.
- State, counts, err, frame_done registered; handshake outputs and coefficients combinational from state and inputs (zero added latency through the block).
- start in cycle n -> busy high n+1; first window may be accepted n+1.
- Final feature handshake in cycle m -> DONE in m+1 (frame_done high), IDLE in m+2.
- win_valid must be held by the line buffer until win_ready; no throttling mid-window in RUN.

## Configuration
- EDGE_BINARIZE_EN defined: extra input threshold [7:0]; out_data = 8'hFF if feat_data >= threshold else 8'h00.
- Not defined: no threshold port; out_data = feat_data.

## Structure
- Shared package: state encoding, Sobel coefficient constants (32-bit encodings), zero-coefficient constant.
- One sub-module natural: sobel_coeff_rom (kernel_addr -> coeff_x/coeff_y).

## Test plan
- WIDTH=5, HEIGHT=5 (NWIN=9), windows streamed, out_ready=1 -> 9 windows accepted, conv_last_pixel on 9th, frame_done one cycle after 9th feature, err=0.
- kernel_addr sweep 0..15 -> addr 3 gives coeff_x=0xC0000000, coeff_y=0x00000000; addr 7 gives coeff_y=0x40000000; 9..15 give zero.
- out_ready toggled 1-of-3 cycles -> conv_result_ready mirrors out_ready, 9 features delivered in order, no loss.
- abort after 4 windows -> IDLE next cycle, busy=0, no frame_done; following start runs full 9-window frame.
- feat_last on 5th feature -> err=1 sticky through frame_done; cleared by next start.
- rst=0 mid-DRAIN -> next cycle all outputs at reset values; start then completes a normal frame.
